// File: rtl/regfile_sb_pkg.sv
// Shared types for the register file. The 32-bit names below are kept for existing users;
// other widths use the flattened {dst, dstdata} layout sized by wr_entry_w().
package regfile_sb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [XLEN_DEF-1:0] unsigned_32;

  // dst sits above dstdata, the same bit order as one entry of the flattened wr_port bus.
  typedef struct packed {
    logic [AW_DEF-1:0] dst;
    unsigned_32        dstdata;
  } RegfileWriteType;

  function automatic int wr_entry_w(input int xlen, input int aw);
    return xlen + aw;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reservations set a bit, writes clear it, and a reservation beats a
// write that hits the same register in the same cycle.
module regfile_scoreboard #(
  parameter int NREGS  = 32,
  parameter int NUM_WR = 2,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WR-1:0]    wr_valid_i,
  input  logic [NUM_WR*AW-1:0] wr_dst_i,
  input  logic                 rsv_valid_i,
  input  logic [AW-1:0]        rsv_dst_i,
  output logic [NREGS-1:0]     busy_vec_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_valid_i[p]) busy_d[wr_dst_i[p*AW +: AW]] = 1'b0;
    end
    if (rsv_valid_i) busy_d[rsv_dst_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with optional same-cycle write forwarding, write-collision flag,
// and a reservation scoreboard. x0 is hardwired to zero.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_WR*wr_entry_w(XLEN,AW)-1:0] wr_port,
  input  logic [NUM_WR-1:0]                  wr_valid,
  input  logic [NUM_RD*AW-1:0]               rd_addr,
  output logic [NUM_RD*XLEN-1:0]             rd_data,
  output logic [NUM_RD-1:0]                  rd_busy,
  input  logic                               rsv_valid,
  input  logic [AW-1:0]                      rsv_dst,
  output logic [NREGS-1:0]                   busy_vec,
  output logic                               wr_collision
);

  localparam int EW = wr_entry_w(XLEN, AW);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [AW-1:0]   wr_dst  [NUM_WR];
  logic [XLEN-1:0] wr_data [NUM_WR];
  logic [NUM_WR*AW-1:0] wr_dst_flat;
  logic [NUM_WR-1:0]    wr_live;
  logic [AW-1:0]   rd_idx  [NUM_RD];
  logic            wr_collision_q, wr_collision_d;

  // A write is live only when strobed and not aimed at x0; x0 writes vanish everywhere.
  always_comb begin
    wr_dst_flat = '0;
    wr_live     = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wr_dst[p]  = wr_port[p*EW + XLEN +: AW];
      wr_data[p] = wr_port[p*EW +: XLEN];
      wr_dst_flat[p*AW +: AW] = wr_dst[p];
      wr_live[p] = wr_valid[p] && (wr_dst[p] != '0);
    end
  end

  // Ascending port order: the highest-index port writing a register lands last and wins.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_live[p]) regs_d[wr_dst[p]] = wr_data[p];
    end
  end

  always_comb begin
    wr_collision_d = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      for (int q = p + 1; q < NUM_WR; q++) begin
        if (wr_live[p] && wr_live[q] && (wr_dst[p] == wr_dst[q])) wr_collision_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      wr_collision_q <= 1'b0;
    end else begin
      regs_q         <= regs_d;
      wr_collision_q <= wr_collision_d;
    end
  end

  assign wr_collision = wr_collision_q;

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_WR (NUM_WR),
    .AW     (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .wr_valid_i  (wr_live),
    .wr_dst_i    (wr_dst_flat),
    .rsv_valid_i (rsv_valid),
    .rsv_dst_i   (rsv_dst),
    .busy_vec_o  (busy_vec)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic fwd_hit;
      rd_idx[i] = rd_addr[i*AW +: AW];
      rd_data[i*XLEN +: XLEN] = regs_q[rd_idx[i]];
      fwd_hit = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_live[p] && (wr_dst[p] == rd_idx[i])) begin
          fwd_hit = 1'b1;
          if (BYPASS != 0) rd_data[i*XLEN +: XLEN] = wr_data[p];
        end
      end
      // A same-cycle write retires the reservation unless a new one lands on it too.
      rd_busy[i] = busy_vec[rd_idx[i]] &&
                   !((BYPASS != 0) && fwd_hit && !(rsv_valid && (rsv_dst == rd_idx[i])));
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a forwarding instance and a non-forwarding instance share stimulus.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int EXP_W = 32*3 + 2 + 32 + 1;

  logic        clk, rst;
  logic [73:0] wr_port;
  logic [1:0]  wr_valid;
  logic [9:0]  rd_addr;
  logic        rsv_valid;
  logic [4:0]  rsv_dst;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic [31:0] busy_vec, busy_vec_nb;
  logic        coll, coll_nb;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];

  regfile_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .wr_port(wr_port), .wr_valid(wr_valid), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .rsv_valid(rsv_valid), .rsv_dst(rsv_dst),
    .busy_vec(busy_vec), .wr_collision(coll)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .wr_port(wr_port), .wr_valid(wr_valid), .rd_addr(rd_addr),
    .rd_data(rd_data_nb), .rd_busy(rd_busy_nb), .rsv_valid(rsv_valid), .rsv_dst(rsv_dst),
    .busy_vec(busy_vec_nb), .wr_collision(coll_nb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wv;
    logic [4:0]  d0;  logic [31:0] x0;
    logic [4:0]  d1;  logic [31:0] x1;
    logic        rv;  logic [4:0]  rd;
    logic [4:0]  a0;  logic [4:0]  a1;
    logic [31:0] e_r0, e_r1, e_nb0;
    logic [1:0]  e_busy;
    logic [31:0] e_bv;
    logic        e_coll;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic [1:0] wv, input logic [4:0] d0, input logic [31:0] x0,
                              input logic [4:0] d1, input logic [31:0] x1, input logic rv,
                              input logic [4:0] rd, input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] e_r0, input logic [31:0] e_r1,
                              input logic [31:0] e_nb0, input logic [1:0] e_busy,
                              input logic [31:0] e_bv, input logic e_coll);
    vec_t v;
    v.wv = wv; v.d0 = d0; v.x0 = x0; v.d1 = d1; v.x1 = x1; v.rv = rv; v.rd = rd;
    v.a0 = a0; v.a1 = a1; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_nb0 = e_nb0;
    v.e_busy = e_busy; v.e_bv = e_bv; v.e_coll = e_coll;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // driver
  task automatic drive(input logic [1:0] wv, input logic [4:0] d0, input logic [31:0] x0,
                       input logic [4:0] d1, input logic [31:0] x1, input logic rv,
                       input logic [4:0] rd, input logic [4:0] a0, input logic [4:0] a1);
    RegfileWriteType w0, w1;
    w0.dst = d0; w0.dstdata = x0;
    w1.dst = d1; w1.dstdata = x1;
    wr_port   = {w1, w0};
    wr_valid  = wv;
    rsv_valid = rv;
    rsv_dst   = rd;
    rd_addr   = {a1, a0};
  endtask

  initial begin
    logic [EXP_W-1:0] e;
    int unsigned hi;

    rst = 1'b1;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);

    //           wv     d0  x0            d1  x1      rv  rd  a0  a1   r0            r1            nb0           busy   bv            coll
    tbl[0]  = mk(2'b00, 0,  32'h0,        0,  32'h0,  0,  0,  0,  31,  32'h0,        32'h0,        32'h0,        2'b00, 32'h0,        0);
    tbl[1]  = mk(2'b01, 5,  32'hDEADBEEF, 0,  32'h0,  0,  0,  5,  5,   32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        2'b00, 32'h0,        0);
    tbl[2]  = mk(2'b00, 0,  32'h0,        0,  32'h0,  0,  0,  5,  0,   32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2'b00, 32'h0,        0);
    tbl[3]  = mk(2'b01, 0,  32'hFFFFFFFF, 0,  32'h0,  0,  0,  0,  5,   32'h0,        32'hDEADBEEF, 32'h0,        2'b00, 32'h0,        0);
    tbl[4]  = mk(2'b11, 7,  32'h11,       7,  32'h22, 0,  0,  7,  7,   32'h22,       32'h22,       32'h0,        2'b00, 32'h0,        1);
    tbl[5]  = mk(2'b00, 0,  32'h0,        0,  32'h0,  0,  0,  7,  5,   32'h22,       32'hDEADBEEF, 32'h22,       2'b00, 32'h0,        0);
    tbl[6]  = mk(2'b00, 0,  32'h0,        0,  32'h0,  1,  3,  3,  0,   32'h0,        32'h0,        32'h0,        2'b00, 32'h8,        0);
    tbl[7]  = mk(2'b00, 0,  32'h0,        0,  32'h0,  0,  0,  3,  5,   32'h0,        32'hDEADBEEF, 32'h0,        2'b01, 32'h8,        0);
    tbl[8]  = mk(2'b10, 0,  32'h0,        3,  32'hABCD, 0, 0, 3,  3,   32'hABCD,     32'hABCD,     32'h0,        2'b00, 32'h0,        0);
    tbl[9]  = mk(2'b01, 3,  32'h55,       0,  32'h0,  1,  3,  3,  0,   32'h55,       32'h0,        32'hABCD,     2'b00, 32'h8,        0);
    tbl[10] = mk(2'b00, 0,  32'h0,        0,  32'h0,  1,  3,  3,  3,   32'h55,       32'h55,       32'h55,       2'b11, 32'h8,        0);
    tbl[11] = mk(2'b11, 3,  32'h66,       12, 32'h99, 1,  12, 3,  12,  32'h66,       32'h99,       32'h55,       2'b00, 32'h1000,     0);
    tbl[12] = mk(2'b00, 0,  32'h0,        0,  32'h0,  1,  0,  12, 3,   32'h99,       32'h66,       32'h99,       2'b01, 32'h1000,     0);
    tbl[13] = mk(2'b11, 0,  32'h1,        0,  32'h2,  0,  0,  0,  12,  32'h0,        32'h99,       32'h0,        2'b10, 32'h1000,     0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy_vec", 64'(busy_vec), 64'h0);
    chk("rst wr_collision", 64'(coll), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(r), 5'(31 - r));
      #1;
      chk($sformatf("rst x%0d", r), 64'(rd_data[31:0]), 64'h0);
      chk($sformatf("rst x%0d nb", 31 - r), 64'(rd_data_nb[63:32]), 64'h0);
    end

    // table vectors through the expected queue
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].wv, tbl[i].d0, tbl[i].x0, tbl[i].d1, tbl[i].x1, tbl[i].rv, tbl[i].rd,
            tbl[i].a0, tbl[i].a1);
      exp_q.push_back({tbl[i].e_r0, tbl[i].e_r1, tbl[i].e_nb0, tbl[i].e_busy,
                       tbl[i].e_bv, tbl[i].e_coll});
      #2;
      e = exp_q.pop_front();
      chk($sformatf("v%0d rd_data0", i), 64'(rd_data[31:0]),  64'(e[130:99]));
      chk($sformatf("v%0d rd_data1", i), 64'(rd_data[63:32]), 64'(e[98:67]));
      chk($sformatf("v%0d nb rd_data0", i), 64'(rd_data_nb[31:0]), 64'(e[66:35]));
      chk($sformatf("v%0d rd_busy", i), 64'(rd_busy), 64'(e[34:33]));
      if (tbl[i].wv == 2'b00) chk($sformatf("v%0d nb rd_busy", i), 64'(rd_busy_nb), 64'(e[34:33]));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d busy_vec", i), 64'(busy_vec), 64'(e[32:1]));
      chk($sformatf("v%0d nb busy_vec", i), 64'(busy_vec_nb), 64'(e[32:1]));
      chk($sformatf("v%0d wr_collision", i), 64'(coll), 64'(e[0]));
      chk($sformatf("v%0d nb wr_collision", i), 64'(coll_nb), 64'(e[0]));
    end

    // random reads of x0 while random data is written to it
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      hi = $urandom_range(32'hFFFF, 0);
      drive(2'b11, 5'd0, {hi[15:0], 16'hA5A5}, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
      @(posedge clk);
      #1;
      chk($sformatf("x0 rand%0d", k), 64'(rd_data_nb[31:0]), 64'h0);
      chk($sformatf("x0 busy rand%0d", k), 64'(busy_vec[0]), 64'h0);
    end

    // asynchronous reset in the middle of a cycle
    @(negedge clk);
    drive(2'b01, 5'd9, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
    @(posedge clk);
    #1;
    chk("x9 written", 64'(rd_data_nb[31:0]), 64'h1234);
    @(negedge clk);
    drive(2'b11, 5'd20, 32'h1, 5'd20, 32'h2, 1'b1, 5'd9, 5'd9, 5'd20);
    @(posedge clk);
    #1;
    chk("x9 reserved busy_vec", 64'(busy_vec), 64'h1200);
    chk("x20 collision", 64'(coll), 64'h1);
    chk("x20 winner", 64'(rd_data_nb[63:32]), 64'h2);
    drive(2'b01, 5'd9, 32'hBAD, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd20);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst x9", 64'(rd_data_nb[31:0]), 64'h0);
    chk("async rst busy_vec", 64'(busy_vec), 64'h0);
    chk("async rst nb busy_vec", 64'(busy_vec_nb), 64'h0);
    chk("async rst wr_collision", 64'(coll), 64'h0);
    chk("async rst x20", 64'(rd_data_nb[63:32]), 64'h0);
    @(posedge clk);
    #1;
    chk("rst held x9", 64'(rd_data_nb[31:0]), 64'h0);
    chk("rst held busy_vec", 64'(busy_vec), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b01, 5'd4, 32'hCAFE, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
    @(posedge clk);
    #1;
    chk("post rst x4", 64'(rd_data_nb[31:0]), 64'hCAFE);
    chk("post rst x9", 64'(rd_data_nb[63:32]), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
